// File: rtl/dcmi_rdma.sv
// Read-side ring DMA: fetches words from frame RAM into a small prefetch FIFO and streams them out.
// Optional macro DCMI_RDMA_BSWAP_EN byte-reverses the output word for big-endian consumers.
`ifndef DMA_ADDR_LEN
`define DMA_ADDR_LEN 16
`endif

module dcmi_rdma #(
   parameter int ADDR_W     = `DMA_ADDR_LEN,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              block_en,
   input  logic              start,
   input  logic              stop,
   input  logic [ADDR_W-1:0] rd_saddr,
   input  logic [ADDR_W-1:0] rd_len,
   input  logic [ADDR_W-1:0] xfer_len,
   output logic              ram_rd_req,
   output logic [ADDR_W-1:0] ram_raddr,
   input  logic              ram_rd_ack,
   input  logic [31:0]       ram_rdata,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [31:0]       out_data,
   output logic              busy,
   output logic              done_pulse,
   output logic              cfg_err_pulse
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
   localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] saddr_q, len_q, xlen_q;
   logic [ADDR_W-1:0] fetch_cnt, deliv_cnt;
   logic [ADDR_W-1:0] fetch_next, deliv_next, ring_last;
   logic [31:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    fifo_cnt;
   logic [31:0]       head;
   logic              push, pop;

   assign ram_rd_req = (state == RUN) && (fifo_cnt < FULL_CNT);
   assign push       = ram_rd_req && ram_rd_ack;
   assign out_vld    = (fifo_cnt != '0);
   assign pop        = out_vld && out_rdy;
   assign busy       = (state != IDLE);
   assign fetch_next = fetch_cnt + A_ONE;
   assign deliv_next = deliv_cnt + A_ONE;
   assign ring_last  = saddr_q + len_q - A_ONE;
   assign head       = mem[rd_ptr];

`ifdef DCMI_RDMA_BSWAP_EN
   assign out_data = out_vld ? {head[7:0], head[15:8], head[23:16], head[31:24]} : 32'h0;
`else
   assign out_data = out_vld ? head : 32'h0;
`endif

   // NOTE: FIFO storage has no reset; fifo_cnt gates every read, so stale words are never visible.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= ram_rdata;
   end

   // NOTE: all state uses non-blocking assignments; later assignments (stop) deliberately override earlier ones.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         saddr_q       <= '0;
         len_q         <= '0;
         xlen_q        <= '0;
         fetch_cnt     <= '0;
         deliv_cnt     <= '0;
         ram_raddr     <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_cnt      <= '0;
         done_pulse    <= 1'b0;
         cfg_err_pulse <= 1'b0;
      end else if (!block_en) begin
         state         <= IDLE;
         saddr_q       <= '0;
         len_q         <= '0;
         xlen_q        <= '0;
         fetch_cnt     <= '0;
         deliv_cnt     <= '0;
         ram_raddr     <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_cnt      <= '0;
         done_pulse    <= 1'b0;
         cfg_err_pulse <= 1'b0;
      end else begin
         done_pulse    <= 1'b0;
         cfg_err_pulse <= 1'b0;

         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop) begin
            rd_ptr    <= rd_ptr + PTR_ONE;
            deliv_cnt <= deliv_next;
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
            2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
            default: fifo_cnt <= fifo_cnt;
         endcase

         case (state)
            IDLE: begin
               if (start && !stop) begin
                  if (rd_len == '0) begin
                     cfg_err_pulse <= 1'b1;
                  end else begin
                     saddr_q   <= rd_saddr;
                     len_q     <= rd_len;
                     xlen_q    <= xfer_len;
                     ram_raddr <= rd_saddr;
                     fetch_cnt <= '0;
                     deliv_cnt <= '0;
                     wr_ptr    <= '0;
                     rd_ptr    <= '0;
                     fifo_cnt  <= '0;
                     state     <= RUN;
                  end
               end
            end
            RUN: begin
               if (push) begin
                  fetch_cnt <= fetch_next;
                  ram_raddr <= (ram_raddr == ring_last) ? saddr_q : ram_raddr + A_ONE;
                  if (xlen_q != '0 && fetch_next == xlen_q) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && deliv_next == xlen_q) begin
                  state      <= IDLE;
                  done_pulse <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         // Abort wins over everything: drop request, flush FIFO, suppress completion.
         if (stop) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            done_pulse <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dcmi_rdma.sv
// Self-checking bench for dcmi_rdma: table-driven ring transfers plus hand-written
// back-pressure, stall/abort, config-error, clear/reset and byte-order sequences.
`timescale 1ns/1ps

module tb_dcmi_rdma;

   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          block_en = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [AW-1:0] rd_saddr = '0;
   logic [AW-1:0] rd_len = '0;
   logic [AW-1:0] xfer_len = '0;
   logic          ram_rd_req;
   logic [AW-1:0] ram_raddr;
   logic          ram_rd_ack;
   logic [31:0]   ram_rdata;
   logic          out_vld;
   logic          out_rdy = 1'b1;
   logic [31:0]   out_data;
   logic          busy;
   logic          done_pulse;
   logic          cfg_err_pulse;

   logic ack_en = 1'b1;
   logic force_rdata = 1'b0;

   int tests = 0;
   int fails = 0;

   logic [AW-1:0] addr_q[$];
   logic [31:0]   data_q[$];
   int            done_cnt = 0;
   int            cfg_err_cnt = 0;

   always #5 clk = ~clk;

   dcmi_rdma #(.ADDR_W(AW), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rstn(rstn), .block_en(block_en), .start(start), .stop(stop),
      .rd_saddr(rd_saddr), .rd_len(rd_len), .xfer_len(xfer_len),
      .ram_rd_req(ram_rd_req), .ram_raddr(ram_raddr), .ram_rd_ack(ram_rd_ack),
      .ram_rdata(ram_rdata), .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
      .busy(busy), .done_pulse(done_pulse), .cfg_err_pulse(cfg_err_pulse)
   );

   // RAM content: each address holds a distinct, easily recognised word.
   function automatic logic [31:0] data_of(input logic [AW-1:0] a);
      return {a ^ 16'h5A5A, a};
   endfunction

   function automatic logic [31:0] fmt(input logic [31:0] w);
`ifdef DCMI_RDMA_BSWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   assign ram_rd_ack = ack_en;
   assign ram_rdata  = force_rdata ? 32'h1122_3344 : data_of(ram_raddr);

   always @(negedge clk) begin
      if (ram_rd_req && ram_rd_ack) addr_q.push_back(ram_raddr);
      if (out_vld && out_rdy) data_q.push_back(out_data);
      if (done_pulse) done_cnt++;
      if (cfg_err_pulse) cfg_err_cnt++;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      addr_q.delete();
      data_q.delete();
      done_cnt = 0;
      cfg_err_cnt = 0;
   endtask

   task automatic do_start(input logic [AW-1:0] sa, input logic [AW-1:0] ln, input logic [AW-1:0] xl);
      rd_saddr = sa;
      rd_len   = ln;
      xfer_len = xl;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int c = 0; c < budget && done_cnt == 0; c++) tick();
      check("done_seen", 32'(done_cnt != 0), 32'd1);
      repeat (3) tick();
   endtask

   typedef struct packed {
      logic [AW-1:0] saddr;
      logic [AW-1:0] len;
      logic [AW-1:0] xfer;
   } cfg_t;

   typedef struct packed {
      logic [1:0]    id;
      logic [AW-1:0] addr;
   } exp_t;

   cfg_t cfg_tab[3];
   exp_t exp_tab[20];

   initial begin
      cfg_tab = '{
         '{16'h0010, 16'd8, 16'd5},
         '{16'h0020, 16'd4, 16'd10},
         '{16'hFFFE, 16'd4, 16'd5}
      };
      exp_tab = '{
         '{2'd0, 16'h0010}, '{2'd0, 16'h0011}, '{2'd0, 16'h0012}, '{2'd0, 16'h0013}, '{2'd0, 16'h0014},
         '{2'd1, 16'h0020}, '{2'd1, 16'h0021}, '{2'd1, 16'h0022}, '{2'd1, 16'h0023}, '{2'd1, 16'h0020},
         '{2'd1, 16'h0021}, '{2'd1, 16'h0022}, '{2'd1, 16'h0023}, '{2'd1, 16'h0020}, '{2'd1, 16'h0021},
         '{2'd2, 16'hFFFE}, '{2'd2, 16'hFFFF}, '{2'd2, 16'h0000}, '{2'd2, 16'h0001}, '{2'd2, 16'hFFFE}
      };

      // Reset state
      #2;
      check("rst_req",   32'(ram_rd_req), 32'd0);
      check("rst_raddr", 32'(ram_raddr), 32'd0);
      check("rst_vld",   32'(out_vld), 32'd0);
      check("rst_data",  out_data, 32'd0);
      check("rst_busy",  32'(busy), 32'd0);
      tick();
      rstn = 1'b1;
      tick();
      block_en = 1'b1;
      tick();

      // Table-driven ring transfers, ack and ready always high
      for (int t = 0; t < 3; t++) begin
         int k;
         clear_logs();
         do_start(cfg_tab[t].saddr, cfg_tab[t].len, cfg_tab[t].xfer);
         wait_done(200);
         check($sformatf("t%0d_nfetch", t), 32'(addr_q.size()), 32'(cfg_tab[t].xfer));
         check($sformatf("t%0d_nout", t), 32'(data_q.size()), 32'(cfg_tab[t].xfer));
         check($sformatf("t%0d_done_once", t), 32'(done_cnt), 32'd1);
         check($sformatf("t%0d_busy_after", t), 32'(busy), 32'd0);
         k = 0;
         for (int e = 0; e < 20; e++) begin
            if (exp_tab[e].id == 2'(t)) begin
               check($sformatf("t%0d_addr%0d", t, k),
                     32'(k < addr_q.size() ? addr_q[k] : 'x), 32'(exp_tab[e].addr));
               check($sformatf("t%0d_data%0d", t, k),
                     k < data_q.size() ? data_q[k] : 'x, fmt(data_of(exp_tab[e].addr)));
               k++;
            end
         end
      end

      // Back-pressure: continuous mode, consumer stalled -> exactly FIFO_DEPTH fetches
      clear_logs();
      out_rdy = 1'b0;
      do_start(16'h0040, 16'd16, 16'd0);
      repeat (12) tick();
      check("bp_nfetch", 32'(addr_q.size()), 32'd4);
      check("bp_req_low", 32'(ram_rd_req), 32'd0);
      check("bp_vld", 32'(out_vld), 32'd1);
      check("bp_head", out_data, fmt(data_of(16'h0040)));
      out_rdy = 1'b1;
      repeat (10) tick();
      for (int i = 0; i < 8; i++)
         check($sformatf("bp_out%0d", i), i < data_q.size() ? data_q[i] : 'x, fmt(data_of(16'h0040 + 16'(i))));
      do_stop();
      check("bp_stop_busy", 32'(busy), 32'd0);
      check("bp_stop_vld", 32'(out_vld), 32'd0);
      check("bp_no_done", 32'(done_cnt), 32'd0);

      // Ack withheld: request and address must hold; then abort mid-run
      clear_logs();
      ack_en = 1'b0;
      do_start(16'h0030, 16'd8, 16'd20);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("stall_req%0d", i), 32'(ram_rd_req), 32'd1);
         check($sformatf("stall_addr%0d", i), 32'(ram_raddr), 32'h0030);
         tick();
      end
      ack_en = 1'b1;
      repeat (3) tick();
      check("stall_first_addr", 32'(addr_q.size() > 0 ? addr_q[0] : 'x), 32'h0030);
      do_stop();
      check("abort_req", 32'(ram_rd_req), 32'd0);
      check("abort_vld", 32'(out_vld), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      repeat (5) tick();
      check("abort_no_done", 32'(done_cnt), 32'd0);

      // Zero-length ring -> config error, stays idle
      clear_logs();
      do_start(16'h0010, 16'd0, 16'd4);
      check("cfgerr_pulse", 32'(cfg_err_pulse), 32'd1);
      check("cfgerr_busy", 32'(busy), 32'd0);
      tick();
      check("cfgerr_one_cycle", 32'(cfg_err_pulse), 32'd0);

      // Start while busy is ignored, as are config changes mid-transfer
      clear_logs();
      do_start(16'h0010, 16'd8, 16'd5);
      tick();
      do_start(16'h0080, 16'd2, 16'd2);
      wait_done(200);
      check("rebusy_nfetch", 32'(addr_q.size()), 32'd5);
      check("rebusy_last", 32'(addr_q.size() == 5 ? addr_q[4] : 'x), 32'h0014);
      check("rebusy_done", 32'(done_cnt), 32'd1);

      // Synchronous clear via block_en mid-transfer
      do_start(16'h0010, 16'd8, 16'd0);
      repeat (3) tick();
      block_en = 1'b0;
      tick();
      check("ben_req", 32'(ram_rd_req), 32'd0);
      check("ben_raddr", 32'(ram_raddr), 32'd0);
      check("ben_vld", 32'(out_vld), 32'd0);
      check("ben_data", out_data, 32'd0);
      check("ben_busy", 32'(busy), 32'd0);
      block_en = 1'b1;
      tick();

      // Asynchronous reset mid-transfer
      do_start(16'h0010, 16'd8, 16'd0);
      repeat (3) tick();
      #2 rstn = 1'b0;
      #1;
      check("arst_req", 32'(ram_rd_req), 32'd0);
      check("arst_raddr", 32'(ram_raddr), 32'd0);
      check("arst_vld", 32'(out_vld), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      tick();
      rstn = 1'b1;
      tick();

      // Output byte order
      clear_logs();
      force_rdata = 1'b1;
      do_start(16'h0050, 16'd2, 16'd1);
      wait_done(50);
      force_rdata = 1'b0;
`ifdef DCMI_RDMA_BSWAP_EN
      check("bswap_word", data_q.size() > 0 ? data_q[0] : 'x, 32'h4433_2211);
`else
      check("bswap_word", data_q.size() > 0 ? data_q[0] : 'x, 32'h1122_3344);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
